// File: rtl/ram_port_arbiter.sv
// Two-master round-robin arbiter for the shared 32-bit BRAM port of the register-dump path.
// Optional statistics counters are built when ARB_STATS_EN is defined.
module ram_port_arbiter #(
    parameter int AW        = 32,
    parameter int MAX_BURST = 32,
    parameter int BCW       = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    output logic          m0_gnt,
    input  logic          m0_en,
    input  logic [3:0]    m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic [31:0]   m0_rdata,
    output logic          m0_rvalid,
    input  logic          m1_req,
    output logic          m1_gnt,
    input  logic          m1_en,
    input  logic [3:0]    m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic [31:0]   m1_rdata,
    output logic          m1_rvalid,
    output logic          ram_clk,
    output logic          ram_rst,
    output logic          ram_en,
    output logic [3:0]    ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wr_data,
    input  logic [31:0]   ram_rd_data
`ifdef ARB_STATS_EN
    ,
    input  logic          stat_clr,
    output logic [15:0]   stat_beats0,
    output logic [15:0]   stat_beats1,
    output logic [7:0]    stat_preempt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Counter saturates one below the burst limit so "limit reached" stays true until a hand-over.
    localparam logic           PREEMPT_EN = (MAX_BURST != 0);
    localparam logic [BCW-1:0] CNT_SAT    = (MAX_BURST == 0) ? {BCW{1'b1}} : BCW'(MAX_BURST - 1);

    state_t          state_q;
    logic            last_q;
    logic [BCW-1:0]  cnt_q;
    logic            gnt0_q;
    logic            gnt1_q;
    logic            ram_en_q;
    logic [3:0]      ram_we_q;
    logic [AW-1:0]   ram_addr_q;
    logic [31:0]     ram_wr_data_q;
    logic [1:0]      rd_p1_q;
    logic [1:0]      rd_p2_q;
    logic            rvalid0_q;
    logic            rvalid1_q;
    logic [31:0]     rdata0_q;
    logic [31:0]     rdata1_q;

    logic            acc0_s;
    logic            acc1_s;
    logic            limit_s;
    logic            force0_s;
    logic            force1_s;

    assign acc0_s   = m0_en & gnt0_q;
    assign acc1_s   = m1_en & gnt1_q;
    assign limit_s  = (cnt_q == CNT_SAT);
    assign force0_s = PREEMPT_EN & m0_req & acc0_s & limit_s & m1_req;
    assign force1_s = PREEMPT_EN & m1_req & acc1_s & limit_s & m0_req;

    // Ownership state machine: grant, round-robin history and per-tenure beat count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req && (!m1_req || last_q)) begin
                        state_q <= OWN0;
                        gnt0_q  <= 1'b1;
                        last_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (m1_req) begin
                        state_q <= OWN1;
                        gnt1_q  <= 1'b1;
                        last_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OWN0: begin
                    if (!m0_req || force0_s) begin
                        gnt0_q <= 1'b0;
                        cnt_q  <= '0;
                        if (m1_req) begin
                            state_q <= OWN1;
                            gnt1_q  <= 1'b1;
                            last_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (acc0_s && !limit_s) begin
                        cnt_q <= cnt_q + BCW'(1);
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                OWN1: begin
                    if (!m1_req || force1_s) begin
                        gnt1_q <= 1'b0;
                        cnt_q  <= '0;
                        if (m0_req) begin
                            state_q <= OWN0;
                            gnt0_q  <= 1'b1;
                            last_q  <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (acc1_s && !limit_s) begin
                        cnt_q <= cnt_q + BCW'(1);
                    end else begin
                        cnt_q <= cnt_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // BRAM port register: copy the owner's accepted beat, otherwise idle with address/data held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_q      <= 1'b0;
            ram_we_q      <= 4'h0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= 32'h0;
        end else if (acc0_s) begin
            ram_en_q      <= 1'b1;
            ram_we_q      <= m0_we;
            ram_addr_q    <= m0_addr;
            ram_wr_data_q <= m0_wdata;
        end else if (acc1_s) begin
            ram_en_q      <= 1'b1;
            ram_we_q      <= m1_we;
            ram_addr_q    <= m1_addr;
            ram_wr_data_q <= m1_wdata;
        end else begin
            ram_en_q      <= 1'b0;
            ram_we_q      <= 4'h0;
        end
    end

    // Read return: issuer tag travels with the read so data survives a grant change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_p1_q   <= 2'b00;
            rd_p2_q   <= 2'b00;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            rd_p1_q   <= {acc1_s && (m1_we == 4'h0), acc0_s && (m0_we == 4'h0)};
            rd_p2_q   <= rd_p1_q;
            rvalid0_q <= rd_p2_q[0];
            rvalid1_q <= rd_p2_q[1];
            if (rd_p2_q[0]) begin
                rdata0_q <= ram_rd_data;
            end else begin
                rdata0_q <= rdata0_q;
            end
            if (rd_p2_q[1]) begin
                rdata1_q <= ram_rd_data;
            end else begin
                rdata1_q <= rdata1_q;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] beats0_q;
    logic [15:0] beats1_q;
    logic [7:0]  preempt_q;

    // Saturating usage counters with synchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats0_q  <= 16'h0;
            beats1_q  <= 16'h0;
            preempt_q <= 8'h0;
        end else if (stat_clr) begin
            beats0_q  <= 16'h0;
            beats1_q  <= 16'h0;
            preempt_q <= 8'h0;
        end else begin
            if (acc0_s && (beats0_q != 16'hFFFF)) begin
                beats0_q <= beats0_q + 16'd1;
            end else begin
                beats0_q <= beats0_q;
            end
            if (acc1_s && (beats1_q != 16'hFFFF)) begin
                beats1_q <= beats1_q + 16'd1;
            end else begin
                beats1_q <= beats1_q;
            end
            if ((force0_s || force1_s) && (preempt_q != 8'hFF)) begin
                preempt_q <= preempt_q + 8'd1;
            end else begin
                preempt_q <= preempt_q;
            end
        end
    end

    assign stat_beats0  = beats0_q;
    assign stat_beats1  = beats1_q;
    assign stat_preempt = preempt_q;
`endif

    assign m0_gnt      = gnt0_q;
    assign m1_gnt      = gnt1_q;
    assign m0_rvalid   = rvalid0_q;
    assign m1_rvalid   = rvalid1_q;
    assign m0_rdata    = rdata0_q;
    assign m1_rdata    = rdata1_q;
    assign ram_clk     = clk;
    assign ram_rst     = ~rst_n;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed and random stimulus against a transaction-level model
// with a BRAM behavioural model on the port side.
module tb_ram_port_arbiter;

    localparam int AW = 32;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_en, m1_req, m1_en;
    logic [3:0]    m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          ram_clk, ram_rst, ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wr_data;
    logic [31:0]   ram_rd_data;
`ifdef ARB_STATS_EN
    logic          stat_clr;
    logic [15:0]   stat_beats0, stat_beats1;
    logic [7:0]    stat_preempt;
`endif

    ram_port_arbiter #(.AW(AW), .MAX_BURST(MB), .BCW(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_en(m0_en), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_en(m1_en), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .ram_clk(ram_clk), .ram_rst(ram_rst), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
`ifdef ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_beats0(stat_beats0), .stat_beats1(stat_beats1),
        .stat_preempt(stat_preempt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i) * 32'h0001_0101);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    // BRAM model: one-cycle read latency, byte-enable writes
    logic [31:0] bmem [64];
    bit          bwritten [64];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'h0) begin
                ram_rd_data <= bwritten[ram_addr[7:2]] ? bmem[ram_addr[7:2]] : init_word(int'(ram_addr[7:2]));
            end else begin
                bmem[ram_addr[7:2]] <= merge(bwritten[ram_addr[7:2]] ? bmem[ram_addr[7:2]]
                                             : init_word(int'(ram_addr[7:2])), ram_wr_data, ram_we);
                bwritten[ram_addr[7:2]] <= 1'b1;
            end
        end
    end

    // Reference model state
    typedef struct { int due; int m; logic [31:0] d; } rd_t;
    rd_t         pq[$];
    logic [31:0] shadow [64];
    int          o_owner, o_last, o_beats, cyc;
    logic        e_en, e_rv0, e_rv1;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    int          s_b0, s_b1, s_pre;
    int          total = 0;
    int          bad = 0;
    int          port_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        o_owner = -1; o_last = 1; o_beats = 0;
        e_en = 1'b0; e_we = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_rd0 = 32'h0; e_rd1 = 32'h0;
        s_b0 = 0; s_b1 = 0; s_pre = 0;
        pq.delete();
    endtask

    task automatic drive_port(input int m, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        rd_t r;
        e_en = 1'b1; e_we = we; e_addr = a; e_wd = d;
        if (we == 4'h0) begin
            r.due = cyc + 2; r.m = m; r.d = shadow[a[7:2]];
            pq.push_back(r);
        end else begin
            shadow[a[7:2]] = merge(shadow[a[7:2]], d, we);
        end
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_step();
        logic a0, a1, ro, rx, acc, forced;
        int o;
        rd_t r;
        cyc++;
        if (!rst_n) return;
        a0 = m0_en && (o_owner == 0);
        a1 = m1_en && (o_owner == 1);
        if (a0) drive_port(0, m0_we, m0_addr, m0_wdata);
        else if (a1) drive_port(1, m1_we, m1_addr, m1_wdata);
        else begin e_en = 1'b0; e_we = 4'h0; end
        e_rv0 = 1'b0; e_rv1 = 1'b0;
        while (pq.size() > 0 && pq[0].due == cyc) begin
            r = pq.pop_front();
            if (r.m == 0) begin e_rv0 = 1'b1; e_rd0 = r.d; end
            else begin e_rv1 = 1'b1; e_rd1 = r.d; end
        end
        if (a0 && s_b0 < 65535) s_b0++;
        if (a1 && s_b1 < 65535) s_b1++;
        if (o_owner < 0) begin
            if (m0_req && (!m1_req || o_last == 1)) begin o_owner = 0; o_last = 0; o_beats = 0; end
            else if (m1_req) begin o_owner = 1; o_last = 1; o_beats = 0; end
        end else begin
            o = o_owner;
            ro = (o == 0) ? m0_req : m1_req;
            rx = (o == 0) ? m1_req : m0_req;
            acc = (o == 0) ? a0 : a1;
            forced = ro && acc && (MB != 0) && (o_beats + 1 >= MB) && rx;
            if (!ro || forced) begin
                if (forced && s_pre < 255) s_pre++;
                o_beats = 0;
                if (rx) begin o_owner = 1 - o; o_last = 1 - o; end
                else o_owner = -1;
            end else if (acc) begin
                o_beats++;
            end
        end
`ifdef ARB_STATS_EN
        if (stat_clr) begin s_b0 = 0; s_b1 = 0; s_pre = 0; end
`endif
    endtask

    task automatic check_all();
        chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, (o_owner == 0)});
        chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, (o_owner == 1)});
        chk("ram_en", {31'd0, ram_en}, {31'd0, e_en});
        chk("ram_we", {28'd0, ram_we}, {28'd0, e_we});
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_wr_data", ram_wr_data, e_wd);
        chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, e_rv0});
        chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, e_rv1});
        chk("m0_rdata", m0_rdata, e_rd0);
        chk("m1_rdata", m1_rdata, e_rd1);
        chk("ram_rst", {31'd0, ram_rst}, {31'd0, ~rst_n});
`ifdef ARB_STATS_EN
        chk("stat_beats0", {16'd0, stat_beats0}, 32'(s_b0));
        chk("stat_beats1", {16'd0, stat_beats1}, 32'(s_b1));
        chk("stat_preempt", {24'd0, stat_preempt}, 32'(s_pre));
`endif
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic take(input int m, input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin m0_en = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; end
        else begin m1_en = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; end
        step();
        m0_en = 1'b0; m1_en = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [5:0] idx;
        idx = 6'($urandom_range(0, 63));
        return {24'h0, idx, 2'b00};
    endfunction

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m0_en = 1'b0; m0_we = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_en = 1'b0; m1_we = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
`ifdef ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // single owner write burst
        m0_req = 1'b1;
        step();
        take(0, 4'hF, 32'h0, 32'h0);
        take(0, 4'hF, 32'h4, 32'h1);
        take(0, 4'hF, 32'h8, 32'h2);
        m0_req = 1'b0;
        repeat (3) step();

        // read latency on m1
        m1_req = 1'b1;
        step();
        take(1, 4'h0, 32'h10, $urandom());
        m1_req = 1'b0;
        step();
        step();
        chk("rd_latency_valid", {31'd0, m1_rvalid}, 32'd1);
        chk("rd_latency_data", m1_rdata, 32'hDEADBEEF);
        chk("rd_latency_other", {31'd0, m0_rvalid}, 32'd0);
        step();

        // simultaneous request after reset
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        step();
        chk("dual_first_m0", {31'd0, m0_gnt}, 32'd1);
        take(0, 4'h0, rnd_addr(), 32'h0);
        take(0, 4'h3, rnd_addr(), $urandom());
        m0_req = 1'b0;
        step();
        chk("handover_no_gap", {31'd0, m1_gnt}, 32'd1);
        m1_req = 1'b0;
        repeat (3) step();

        // preemption at the burst limit
`ifdef ARB_STATS_EN
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
`endif
        m0_req = 1'b1;
        step();
        m1_req = 1'b1;
        port_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            m0_en = (o_owner == 0); m0_we = 4'hF; m0_addr = rnd_addr(); m0_wdata = $urandom();
            step();
            if (ram_en) port_cnt++;
        end
        m0_en = 1'b0;
        chk("preempt_beats", 32'(port_cnt), 32'd4);
        chk("preempt_m1_gnt", {31'd0, m1_gnt}, 32'd1);
`ifdef ARB_STATS_EN
        chk("stat_beats0_handover", {16'd0, stat_beats0}, 32'd4);
        chk("stat_preempt_one", {24'd0, stat_preempt}, 32'd1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("stat_clr_b0", {16'd0, stat_beats0}, 32'd0);
        chk("stat_clr_pre", {24'd0, stat_preempt}, 32'd0);
`endif
        m0_req = 1'b0;
        step();
        m1_req = 1'b0;
        repeat (2) step();

        // no contention: all beats pass, m1_en without grant ignored
        m0_req = 1'b1;
        step();
        port_cnt = 0;
        m1_en = 1'b1; m1_we = 4'hF; m1_addr = 32'h20; m1_wdata = 32'hBAD0BAD0;
        for (int i = 0; i < 10; i++) begin
            m0_en = 1'b1; m0_we = 4'hF; m0_addr = rnd_addr(); m0_wdata = $urandom();
            step();
            if (ram_en) port_cnt++;
        end
        m0_en = 1'b0; m1_en = 1'b0;
        chk("no_contention_beats", 32'(port_cnt), 32'd10);
        m0_req = 1'b0;
        repeat (2) step();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) m0_req = ~m0_req;
            if ($urandom_range(0, 5) == 0) m1_req = ~m1_req;
            m0_en = 1'($urandom_range(0, 1));
            m1_en = 1'($urandom_range(0, 1));
            m0_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            m1_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            m0_addr = rnd_addr(); m1_addr = rnd_addr();
            m0_wdata = $urandom(); m1_wdata = $urandom();
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0; m0_en = 1'b0; m1_en = 1'b0;
        repeat (4) step();

        // reset in the middle of a read burst
        m0_req = 1'b1;
        step();
        take(0, 4'h0, rnd_addr(), 32'h0);
        take(0, 4'h0, rnd_addr(), 32'h0);
        m0_en = 1'b1; m0_we = 4'h0; m0_addr = rnd_addr();
        model_step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        m0_en = 1'b0; m1_req = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("rst_restart_m0", {31'd0, m0_gnt}, 32'd1);
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single 32-bit BRAM port of the register-dump path between two masters.
  - m0: register-dump sequencer.
  - m1: debug/trace writer or reader.
- Round-robin grant with burst lock and optional burst-length preemption.
- Registers the selected access onto the BRAM port and routes 1-cycle-latency read data back to the issuing master.
- Sits between the dump/trace engines and the BRAM controller.

Parameters:
- AW, 32, width of the address bus (byte address).
- MAX_BURST, 32, accepted beats before forced hand-over when the other master is waiting; 0 = no limit.
- BCW, 6, width of the beat counter; must hold MAX_BURST.

Ports:
- clk  in  1  clock; also drives ram_clk.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  m0 requests port ownership; held for the whole burst.
- m0_gnt  out  1  m0 owns the port (registered).
- m0_en  in  1  m0 access strobe; accepted only when m0_gnt=1.
- m0_we  in  4  m0 byte write enables; 0 = read.
- m0_addr  in  AW  m0 address.
- m0_wdata  in  32  m0 write data.
- m0_rdata  out  32  read data to m0.
- m0_rvalid  out  1  m0_rdata valid, 1-cycle pulse.
- m1_req, m1_gnt, m1_en, m1_we, m1_addr, m1_wdata, m1_rdata, m1_rvalid: same as m0, for m1.
- ram_clk  out  1  equal to clk.
- ram_rst  out  1  equal to ~rst_n (active high).
- ram_en  out  1  BRAM enable (registered).
- ram_we  out  4  BRAM byte write enables (registered).
- ram_addr  out  AW  BRAM address (registered).
- ram_wr_data  out  32  BRAM write data (registered).
- ram_rd_data  in  32  BRAM read data, valid 1 cycle after a read on the port.

Behaviour:
- Clocking and reset:
  - Reset rst_n, asynchronous, active-low; clock clk; all state updates on posedge clk.
  - Reset values: gnt=0 for both masters; ram_en=0, ram_we=0, ram_addr=0, ram_wr_data=0; rvalid=0; rdata=0; state IDLE; last=1 (so m0 wins first); beat counter 0.
- States: IDLE, OWN0, OWN1.
  - IDLE: if m0_req and m1_req, grant the master not equal to last; else grant whichever requests; else stay.
  - The grant appears the cycle after req is seen.
  - OWNn: leave when mn_req=0.
    - Go to OWN(other) if the other req=1, else IDLE.
    - Grant switches at the next edge; there is no idle gap when the other is waiting.
  - OWNn preemption: MAX_BURST≠0, an accepted beat with counter==MAX_BURST-1, and the other req=1 → go to OWN(other) at the next edge. The owner sees gnt drop and must re-request.
  - Without a waiting master the counter saturates and the owner keeps the port.
  - last is updated to the owner on every grant; beat counter clears on every grant change.
- Accept and port drive:
  - A beat is accepted when mn_en & mn_gnt.
  - Next edge: ram_en=1, and ram_we, ram_addr, ram_wr_data copy the owner's inputs.
  - Otherwise ram_en=0 and ram_we=0; address and data hold.
  - mn_en while mn_gnt=0 is ignored: no port activity and no error.
- Read return:
  - An accepted beat with we=0 is tagged with its master.
  - Read issued at cycle t → port at t+1 → mn_rvalid=1 and mn_rdata=ram_rd_data (registered) at t+2.
  - Back-to-back reads give one rvalid per cycle.
  - A read in flight across a grant change still returns to its issuer.
- Writes never generate rvalid.
- m0_gnt and m1_gnt are never both 1.
- Reset mid-burst: port drops immediately (asynchronous) and in-flight reads are discarded; after release, arbitration restarts from IDLE with last=1.

Optional Feature:
- Macro ARB_STATS_EN.
- When defined, adds:
  - input stat_clr (synchronous, clears all counters);
  - outputs stat_beats0[15:0], stat_beats1[15:0] (accepted beats per master, saturating at 16'hFFFF);
  - output stat_preempt[7:0] (forced hand-overs, saturating).
- All counters reset to 0.
- When undefined: these ports and counters are absent and the behaviour above is unchanged.

Test Plan:
- Single owner write: m0_req=1; after m0_gnt, 3 beats with we=4'hF, addr 0/4/8, data 0/1/2 → ram_en=1 for 3 consecutive cycles one cycle later, same addr/data order, ram_we=4'hF; no rvalid.
- Read latency: m1 owns and reads addr 0x10 at cycle t with ram_rd_data=0xDEADBEEF at t+2 → m1_rvalid pulses at t+2 with m1_rdata=0xDEADBEEF; m0_rvalid stays 0.
- Simultaneous request after reset: m0_req=m1_req=1 in the same cycle → m0_gnt first; when m0 releases, m1_gnt=1 on the next edge with no IDLE cycle.
- Preemption, MAX_BURST=4: m0 streams 10 beats and m1_req is held → exactly 4 m0 beats reach the port, then m1_gnt=1. With m1_req=0, all 10 m0 beats pass.
- Reset mid-burst: assert rst_n=0 during an m0 read burst → ram_en, gnt and rvalid are 0 immediately; after release, no stale rvalid, and m0 is granted first on a dual request.
- ARB_STATS_EN: run the preemption case → stat_beats0=4 at hand-over, stat_preempt=1; pulse stat_clr → all counters read 0.
